// File: rtl/camera_pkg.sv
// Shared definitions for the camera capture block: screen geometry defaults,
// RGB565 colour constants, capture FSM state encoding and the colour-bar
// helper used when the design is built with CAPTURE_TEST_PATTERN_EN.
package camera_pkg;

  localparam int DEFAULT_SCREEN_WIDTH  = 176;
  localparam int DEFAULT_SCREEN_HEIGHT = 144;

  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] BLACK = 16'h0000;

  // Column boundaries of the three vertical colour bars
  localparam logic [7:0] PATTERN_GREEN_X = 8'd59;
  localparam logic [7:0] PATTERN_BLUE_X  = 8'd118;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    IDLE    = 2'd1,
    LO_BYTE = 2'd2,
    HI_BYTE = 2'd3
  } capture_state_t;

  function automatic logic [15:0] test_pattern(input logic [7:0] x);
    logic [15:0] colour;
    if (x < PATTERN_GREEN_X) begin
      colour = RED;
    end else if (x < PATTERN_BLUE_X) begin
      colour = GREEN;
    end else begin
      colour = BLUE;
    end
    return colour;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers the camera sync inputs and produces single-cycle edge strobes:
// vsync_rise marks the start of vertical blanking, href_fall the end of a line.
// The strobes are valid in the same cycle the new input level is presented.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic vsync_rise,
  output logic href_fall
);

  logic vsync_q;
  logic href_q;

  // Remember last cycle's VSYNC and HREF levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
    end
  end

  assign vsync_rise = vsync & ~vsync_q;
  assign href_fall  = ~href & href_q;

endmodule

// File: rtl/camera_capture.sv
// Camera capture front end: assembles RGB565 pixels from an 8-bit camera bus
// (low byte first), tracks column/row counters and emits frame-buffer write
// strobes with addresses. Define CAPTURE_TEST_PATTERN_EN to replace the camera
// bytes with a red/green/blue colour-bar pattern while keeping all timing.
import camera_pkg::*;

module camera_capture #(
  parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        VSYNC,
  input  logic        HREF,
  input  logic [7:0]  CAM_DATA,
  output logic [15:0] PIXEL_OUT,
  output logic        PIXEL_VALID,
  output logic [7:0]  X_ADDR,
  output logic [7:0]  Y_ADDR,
  output logic [14:0] W_ADDR,
  output logic        FRAME_DONE,
  output logic        LINE_ERR
);

  localparam logic [7:0]  WIDTH_LIM  = 8'(SCREEN_WIDTH);
  localparam logic [7:0]  HEIGHT_LIM = 8'(SCREEN_HEIGHT);
  localparam logic [14:0] WIDTH_15   = 15'(SCREEN_WIDTH);

  capture_state_t state;
  capture_state_t next_state;

  logic vsync_rise;
  logic href_fall;

  // Control strobes decoded by the FSM for the datapath
  logic sync_clear;
  logic frame_end;
  logic err_set;
  logic lo_latch;
  logic hi_latch;
  logic line_end;

  logic [7:0]  x_cnt;
  logic [7:0]  y_cnt;
  logic        line_has_pixel;
  logic        pixel_in_window;
  logic [14:0] addr_calc;

  sync_edge_detect u_sync_edge_detect (
    .clk        (CLK),
    .rst        (RESET),
    .vsync      (VSYNC),
    .href       (HREF),
    .vsync_rise (vsync_rise),
    .href_fall  (href_fall)
  );

  assign pixel_in_window = (x_cnt < WIDTH_LIM) && (y_cnt < HEIGHT_LIM);
  assign addr_calc       = 15'(x_cnt) + (15'(y_cnt) * WIDTH_15);

  // Capture state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= SYNC;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; a VSYNC rise always wins over any HREF activity
  always_comb begin
    next_state = state;
    sync_clear = 1'b0;
    frame_end  = 1'b0;
    err_set    = 1'b0;
    lo_latch   = 1'b0;
    hi_latch   = 1'b0;
    line_end   = 1'b0;
    case (state)
      SYNC: begin
        if (VSYNC) begin
          sync_clear = 1'b1;
          next_state = IDLE;
        end
      end
      IDLE: begin
        if (vsync_rise) begin
          frame_end = 1'b1;
        end else if (!VSYNC && HREF) begin
          lo_latch   = 1'b1;
          next_state = HI_BYTE;
        end
      end
      HI_BYTE: begin
        if (vsync_rise) begin
          frame_end  = 1'b1;
          err_set    = 1'b1;
          next_state = IDLE;
        end else if (href_fall || !HREF) begin
          err_set    = 1'b1;
          line_end   = 1'b1;
          next_state = IDLE;
        end else begin
          hi_latch   = 1'b1;
          next_state = LO_BYTE;
        end
      end
      LO_BYTE: begin
        if (vsync_rise) begin
          frame_end  = 1'b1;
          next_state = IDLE;
        end else if (href_fall || !HREF) begin
          line_end   = 1'b1;
          next_state = IDLE;
        end else begin
          lo_latch   = 1'b1;
          next_state = HI_BYTE;
        end
      end
      default: begin
        next_state = SYNC;
      end
    endcase
  end

  // Column/row counters; a line that delivered no pixel does not advance the row
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_cnt          <= 8'd0;
      y_cnt          <= 8'd0;
      line_has_pixel <= 1'b0;
    end else if (sync_clear || frame_end) begin
      x_cnt          <= 8'd0;
      y_cnt          <= 8'd0;
      line_has_pixel <= 1'b0;
    end else if (line_end) begin
      if (line_has_pixel) begin
        x_cnt <= 8'd0;
        if (y_cnt < HEIGHT_LIM) begin
          y_cnt <= y_cnt + 8'd1;
        end
      end
      line_has_pixel <= 1'b0;
    end else if (hi_latch) begin
      if (x_cnt < WIDTH_LIM) begin
        x_cnt <= x_cnt + 8'd1;
      end
      line_has_pixel <= 1'b1;
    end
  end

  // Registered write strobe and addresses, one cycle after the high byte
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PIXEL_VALID <= 1'b0;
      X_ADDR      <= 8'd0;
      Y_ADDR      <= 8'd0;
      W_ADDR      <= 15'd0;
    end else begin
      PIXEL_VALID <= hi_latch && pixel_in_window;
      if (hi_latch && pixel_in_window) begin
        X_ADDR <= x_cnt;
        Y_ADDR <= y_cnt;
        W_ADDR <= addr_calc;
      end
    end
  end

  // Frame-end strobe and sticky line error flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FRAME_DONE <= 1'b0;
      LINE_ERR   <= 1'b0;
    end else begin
      FRAME_DONE <= frame_end;
      if (err_set) begin
        LINE_ERR <= 1'b1;
      end
    end
  end

`ifdef CAPTURE_TEST_PATTERN_EN
  // Colour-bar pixel chosen by the column the pixel lands in
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PIXEL_OUT <= BLACK;
    end else if (hi_latch) begin
      PIXEL_OUT <= test_pattern(x_cnt);
    end
  end
`else
  // Pixel assembly from the camera bus, low byte then high byte
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PIXEL_OUT <= BLACK;
    end else begin
      if (lo_latch) begin
        PIXEL_OUT[7:0] <= CAM_DATA;
      end
      if (hi_latch) begin
        PIXEL_OUT[15:8] <= CAM_DATA;
      end
    end
  end
`endif

endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard testbench for camera_capture: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every PIXEL_VALID strobe.
`timescale 1ns/1ps

module tb_camera_capture;

  localparam int W = 176;
  localparam int H = 144;

  logic        CLK;
  logic        RESET;
  logic        VSYNC;
  logic        HREF;
  logic [7:0]  CAM_DATA;
  logic [15:0] PIXEL_OUT;
  logic        PIXEL_VALID;
  logic [7:0]  X_ADDR;
  logic [7:0]  Y_ADDR;
  logic [14:0] W_ADDR;
  logic        FRAME_DONE;
  logic        LINE_ERR;

  typedef struct {
    logic [15:0] pix;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [14:0] w;
  } exp_t;

  exp_t expQ[$];

  int checkCount = 0;
  int passCount = 0;
  int strobeCount = 0;
  int frameDoneCount = 0;
  int lastWAddr = -1;

  camera_capture #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .VSYNC       (VSYNC),
    .HREF        (HREF),
    .CAM_DATA    (CAM_DATA),
    .PIXEL_OUT   (PIXEL_OUT),
    .PIXEL_VALID (PIXEL_VALID),
    .X_ADDR      (X_ADDR),
    .Y_ADDR      (Y_ADDR),
    .W_ADDR      (W_ADDR),
    .FRAME_DONE  (FRAME_DONE),
    .LINE_ERR    (LINE_ERR)
  );

  // 100 MHz pixel clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the run wedges
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Expected pixel value: camera bytes, or the colour bars when built with the pattern
  function automatic logic [15:0] expPixel(input logic [7:0] hi, input logic [7:0] lo, input int x);
`ifdef CAPTURE_TEST_PATTERN_EN
    if (x < 59) return 16'hF800;
    else if (x < 118) return 16'h07E0;
    else return 16'h001F;
`else
    return {hi, lo};
`endif
  endfunction

  function automatic logic [7:0] byteVal(input int lineId, input int idx);
    return 8'((idx * 7) + (lineId * 13) + 5);
  endfunction

  task automatic pushExp(input logic [15:0] pix, input int x, input int y);
    exp_t e;
    e.pix = pix;
    e.x   = 8'(x);
    e.y   = 8'(y);
    e.w   = 15'(y * W + x);
    expQ.push_back(e);
  endtask

  // Present one cycle's worth of camera inputs, changed just after the rising edge
  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge CLK);
    #1;
    VSYNC    = vs;
    HREF     = hr;
    CAM_DATA = d;
  endtask

  task automatic vsyncPulse();
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  // One line of nBytes; pixels are expected only when the row is inside the frame
  task automatic sendLine(input int nBytes, input int lineId, input int row, input bit expectPix);
    for (int b = 0; b < nBytes; b++) begin
      applyStimulus(1'b0, 1'b1, byteVal(lineId, b));
      if ((b % 2) == 1 && expectPix && (b / 2) < W && row < H) begin
        pushExp(expPixel(byteVal(lineId, b), byteVal(lineId, b - 1), b / 2), b / 2, row);
      end
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic checkResetOutputs(input string tag);
    @(negedge CLK);
    checkOutput({tag, "_pixel_out"}, 32'(PIXEL_OUT), 32'h0);
    checkOutput({tag, "_pixel_valid"}, 32'(PIXEL_VALID), 32'h0);
    checkOutput({tag, "_x_addr"}, 32'(X_ADDR), 32'h0);
    checkOutput({tag, "_y_addr"}, 32'(Y_ADDR), 32'h0);
    checkOutput({tag, "_w_addr"}, 32'(W_ADDR), 32'h0);
    checkOutput({tag, "_frame_done"}, 32'(FRAME_DONE), 32'h0);
    checkOutput({tag, "_line_err"}, 32'(LINE_ERR), 32'h0);
  endtask

  // Monitor: count strobes and frame ends, compare every strobe against the scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (FRAME_DONE) frameDoneCount++;
    if (PIXEL_VALID) begin
      strobeCount++;
      lastWAddr = int'(W_ADDR);
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_valid: got strobe at X=%0d Y=%0d, required none", X_ADDR, Y_ADDR);
      end else begin
        e = expQ.pop_front();
        checkOutput("pixel_out", 32'(PIXEL_OUT), 32'(e.pix));
        checkOutput("x_addr", 32'(X_ADDR), 32'(e.x));
        checkOutput("y_addr", 32'(Y_ADDR), 32'(e.y));
        checkOutput("w_addr", 32'(W_ADDR), 32'(e.w));
      end
    end
  end

  // Directed test sequence
  initial begin
    int base;
    RESET    = 1'b1;
    VSYNC    = 1'b0;
    HREF     = 1'b0;
    CAM_DATA = 8'h00;
    repeat (3) @(posedge CLK);
    checkResetOutputs("reset");
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // First VSYNC after reset only arms capture
    vsyncPulse();
    checkOutput("first_vsync_no_frame_done", 32'(frameDoneCount), 32'd0);

    // Basic two-pixel line
    applyStimulus(1'b0, 1'b1, 8'h1F);
    applyStimulus(1'b0, 1'b1, 8'hF8);
    pushExp(expPixel(8'hF8, 8'h1F, 0), 0, 0);
    applyStimulus(1'b0, 1'b1, 8'hE0);
    applyStimulus(1'b0, 1'b1, 8'h07);
    pushExp(expPixel(8'h07, 8'hE0, 1), 1, 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("basic_line_strobes", 32'(strobeCount), 32'd2);

    // Full frame
    vsyncPulse();
    checkOutput("frame_done_after_vsync1", 32'(frameDoneCount), 32'd1);
    base = strobeCount;
    for (int l = 0; l < H; l++) sendLine(2 * W, l, l, 1'b1);
    checkOutput("full_frame_strobes", 32'(strobeCount - base), 32'd25344);
    checkOutput("full_frame_last_w", 32'(lastWAddr), 32'd25343);
    checkOutput("no_frame_done_mid_frame", 32'(frameDoneCount), 32'd1);
    base = strobeCount;
    sendLine(8, 500, H, 1'b0);
    checkOutput("row_saturated_no_strobes", 32'(strobeCount - base), 32'd0);
    vsyncPulse();
    checkOutput("frame_done_once", 32'(frameDoneCount), 32'd2);

    // Overlong line then an odd-length line
    base = strobeCount;
    sendLine(400, 7, 0, 1'b1);
    checkOutput("long_line_strobes", 32'(strobeCount - base), 32'd176);
    checkOutput("line_err_clear_before_odd", 32'(LINE_ERR), 32'd0);
    base = strobeCount;
    sendLine(3, 8, 1, 1'b1);
    checkOutput("odd_line_strobes", 32'(strobeCount - base), 32'd1);
    checkOutput("odd_line_err", 32'(LINE_ERR), 32'd1);

    // VSYNC cutting a half pixel on line 5, together with HREF falling
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    checkResetOutputs("reset2");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    vsyncPulse();
    checkOutput("vsync_after_reset_no_frame_done", 32'(frameDoneCount), 32'd2);
    for (int l = 0; l < 5; l++) sendLine(4, 20 + l, l, 1'b1);
    for (int b = 0; b < 3; b++) applyStimulus(1'b0, 1'b1, byteVal(30, b));
    pushExp(expPixel(byteVal(30, 1), byteVal(30, 0), 0), 0, 5);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("cut_line_frame_done", 32'(frameDoneCount), 32'd3);
    checkOutput("cut_line_err", 32'(LINE_ERR), 32'd1);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    sendLine(4, 31, 0, 1'b1);

    // Reset in the middle of line 70
    vsyncPulse();
    checkOutput("frame_done_before_reset_test", 32'(frameDoneCount), 32'd4);
    for (int l = 0; l < 70; l++) sendLine(4, 40 + l, l, 1'b1);
    for (int b = 0; b < 5; b++) begin
      applyStimulus(1'b0, 1'b1, byteVal(110, b));
      if (b == 1 || b == 3) pushExp(expPixel(byteVal(110, b), byteVal(110, b - 1), b / 2), b / 2, 70);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    checkResetOutputs("mid_frame_reset");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    base = strobeCount;
    for (int b = 0; b < 6; b++) applyStimulus(1'b0, 1'b1, byteVal(111, b));
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
    sendLine(8, 112, 71, 1'b0);
    checkOutput("no_strobes_after_reset", 32'(strobeCount - base), 32'd0);
    vsyncPulse();
    checkOutput("no_frame_done_after_reset", 32'(frameDoneCount), 32'd4);
    sendLine(6, 113, 0, 1'b1);
    checkOutput("resume_strobes", 32'(strobeCount - base), 32'd3);

    // Let any outstanding strobes reach the monitor
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge CLK);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
